// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-access stage driving a req/ack data port
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [2:0]              lat_funct3;
    logic [1:0]              lat_off;

    logic                    dec_illegal;
    logic                    dec_misaligned;
    logic [3:0]              dec_be;
    logic [DATA_WIDTH-1:0]   dec_wdata;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   load_data;

    assign o_ready = (state == IDLE);

    // Decode the incoming request: legality, alignment, byte lanes and replicated store data
    always_comb begin
        dec_illegal    = 1'b0;
        dec_misaligned = 1'b0;
        dec_be         = 4'b1111;
        dec_wdata      = i_wdata;
        if (i_we) begin
            case (i_funct3)
                3'b000: begin
                    dec_be    = 4'b0001 << i_addr[1:0];
                    dec_wdata = {4{i_wdata[7:0]}};
                end
                3'b001: begin
                    dec_be    = 4'b0011 << i_addr[1:0];
                    dec_wdata = {2{i_wdata[15:0]}};
                end
                3'b010:  dec_be = 4'b1111;
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                3'b011, 3'b110, 3'b111: dec_illegal = 1'b1;
                default:                dec_illegal = 1'b0;
            endcase
        end
        case (i_funct3[1:0])
            2'b01:   dec_misaligned = i_addr[0];
            2'b10:   dec_misaligned = |i_addr[1:0];
            default: dec_misaligned = 1'b0;
        endcase
    end

    // Extract and extend the addressed byte/halfword from the returned memory word
    always_comb begin
        ld_byte = i_mem_rdata[{lat_off, 3'b000} +: 8];
        ld_half = i_mem_rdata[{lat_off[1], 4'b0000} +: 16];
        case (lat_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = i_mem_rdata;
        endcase
    end

    // Transaction FSM with registered memory-side and response outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_funct3  <= 3'd0;
            lat_off     <= 2'd0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= 4'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (dec_illegal || dec_misaligned) begin
                            state   <= RESP;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= '0;
                        end else begin
                            state       <= ACCESS;
                            cnt         <= '0;
                            lat_funct3  <= i_funct3;
                            lat_off     <= i_addr[1:0];
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_we;
                            o_mem_addr  <= {i_addr[DATA_WIDTH-1:2], 2'b00};
                            o_mem_wdata <= dec_wdata;
                            o_mem_be    <= dec_be;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (i_mem_ack) begin
                        state     <= RESP;
                        o_done    <= 1'b1;
                        o_err     <= 1'b0;
                        o_mem_req <= 1'b0;
                        o_rdata   <= o_mem_we ? '0 : load_data;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        o_done    <= 1'b1;
                        o_err     <= 1'b1;
                        o_mem_req <= 1'b0;
                        o_rdata   <= '0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
